// File: rtl/riscv_imem_loader.sv
// Streams a program into instruction memory, then holds the core in reset for a
// fixed number of cycles before releasing it.
module riscv_imem_loader #(
  parameter int IMEM_ADDR_BIT = 10,
  parameter int CORE_RST_HOLD = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_load_start,
  input  logic [IMEM_ADDR_BIT:0]   i_word_count,
  input  logic                     i_valid,
  input  logic [31:0]              i_data,
  output logic                     o_ready,
  output logic                     o_imem_we,
  output logic [IMEM_ADDR_BIT-1:0] o_imem_addr,
  output logic [31:0]              o_imem_wdata,
  output logic                     o_core_rstn,
  output logic                     o_done,
  output logic                     o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam int unsigned            DEPTH_I   = 1 << IMEM_ADDR_BIT;
  localparam logic [IMEM_ADDR_BIT:0] DEPTH     = DEPTH_I[IMEM_ADDR_BIT:0];
  localparam logic [IMEM_ADDR_BIT:0] ONE       = (IMEM_ADDR_BIT+1)'(1);
  // Loaded on HOLD entry so the state lasts exactly CORE_RST_HOLD cycles.
  localparam logic [7:0]             HOLD_INIT = 8'(CORE_RST_HOLD - 1);

  state_t                 state_r, state_s;
  logic [IMEM_ADDR_BIT:0] count_r, count_s;
  logic [IMEM_ADDR_BIT:0] idx_r, idx_s;
  logic [7:0]             hold_r, hold_s;
  logic                   err_r, err_s;
  logic                   handshake_s;
  logic                   we_r;
  logic [IMEM_ADDR_BIT-1:0] addr_r;
  logic [31:0]            wdata_r;
  logic                   core_rstn_r;
  logic                   done_r;

  assign o_ready     = (state_r == ST_LOAD);
  assign handshake_s = (state_r == ST_LOAD) && i_valid;

  // Next-state and bookkeeping decode.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    idx_s   = idx_r;
    hold_s  = hold_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (i_load_start) begin
          if (i_word_count == '0) begin
            state_s = ST_HOLD;
            hold_s  = HOLD_INIT;
            err_s   = 1'b0;
          end else if (i_word_count > DEPTH) begin
            err_s = 1'b1;
          end else begin
            state_s = ST_LOAD;
            count_s = i_word_count;
            idx_s   = '0;
            err_s   = 1'b0;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (handshake_s) begin
          idx_s = idx_r + ONE;
          if (idx_r == count_r - ONE) begin
            state_s = ST_HOLD;
            hold_s  = HOLD_INIT;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_r == 8'd0) begin
          state_s = ST_RUN;
        end else begin
          hold_s = hold_r - 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Word count, index, hold counter and sticky error.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_r <= '0;
      idx_r   <= '0;
      hold_r  <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_s;
      idx_r   <= idx_s;
      hold_r  <= hold_s;
      err_r   <= err_s;
    end
  end

  // Registered write stage and core control; a pending write is dropped on reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 32'd0;
      core_rstn_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      we_r        <= handshake_s;
      if (handshake_s) begin
        addr_r  <= idx_r[IMEM_ADDR_BIT-1:0];
        wdata_r <= i_data;
      end
      core_rstn_r <= (state_s == ST_RUN);
      done_r      <= (state_s == ST_RUN);
    end
  end

  assign o_imem_we    = we_r;
  assign o_imem_addr  = addr_r;
  assign o_imem_wdata = wdata_r;
  assign o_core_rstn  = core_rstn_r;
  assign o_done       = done_r;
  assign o_err        = err_r;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Randomized self-checking bench for riscv_imem_loader against a transaction-level
// model: expected writes, ready window and release timing derived per load.
module tb_riscv_imem_loader;
  localparam int AW   = 10;
  localparam int HOLD = 4;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_load_start;
  logic [AW:0]   i_word_count;
  logic          i_valid;
  logic [31:0]   i_data;
  logic          o_ready;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_core_rstn;
  logic          o_done;
  logic          o_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] prog [3];
  logic        pat  [7];

  riscv_imem_loader #(.IMEM_ADDR_BIT(AW), .CORE_RST_HOLD(HOLD)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_load_start(i_load_start),
    .i_word_count(i_word_count), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_core_rstn(o_core_rstn), .o_done(o_done),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // mode: 0 = valid always high, 1 = random valid, 2 = fixed pattern
  task automatic do_load(input int count, input int mode, input bit use_prog);
    int sent;
    int budget;
    logic v;
    logic [31:0] d;
    i_load_start = 1'b1;
    i_word_count = (AW+1)'(count);
    tick();
    i_load_start = 1'b0;
    check_val("start_core_rstn", o_core_rstn, 0);
    check_val("start_done", o_done, 0);
    check_val("start_err", o_err, 0);
    check_val("start_we", o_imem_we, 0);
    sent = 0;
    budget = 0;
    while (sent < count && budget < count * 20 + 20) begin
      check_val("ready_in_load", o_ready, 1);
      if (mode == 0) v = 1'b1;
      else if (mode == 2) v = pat[budget % 7];
      else v = 1'($urandom_range(0, 1));
      d = use_prog ? prog[sent] : $urandom;
      i_valid = v;
      i_data  = d;
      tick();
      budget++;
      check_val("we", o_imem_we, 64'(v));
      if (v) begin
        check_val("addr", o_imem_addr, 64'(sent));
        check_val("wdata", o_imem_wdata, d);
        sent++;
      end
    end
    i_valid = 1'b0;
    check_val("load_complete", 64'(sent), 64'(count));
    check_val("ready_after_load", o_ready, 0);
    check_val("hold_core_rstn", o_core_rstn, 0);
    for (int k = 1; k < HOLD; k++) begin
      tick();
      check_val("hold_core_rstn", o_core_rstn, 0);
      check_val("hold_done", o_done, 0);
      check_val("hold_we", o_imem_we, 0);
      check_val("hold_ready", o_ready, 0);
    end
    tick();
    check_val("run_core_rstn", o_core_rstn, 1);
    check_val("run_done", o_done, 1);
    check_val("run_ready", o_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    i_rstn = 1'b0;
    i_load_start = 1'b0;
    i_word_count = '0;
    i_valid = 1'b0;
    i_data = 32'd0;

    #2;
    check_val("rst_core_rstn", o_core_rstn, 0);
    check_val("rst_we", o_imem_we, 0);
    check_val("rst_ready", o_ready, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_err", o_err, 0);
    tick();
    tick();
    i_rstn = 1'b1;
    tick();
    tick();
    check_val("idle_ready", o_ready, 0);
    check_val("idle_core_rstn", o_core_rstn, 0);

    // Oversized count: sticky error, no load.
    i_load_start = 1'b1;
    i_word_count = (AW+1)'((1 << AW) + 1);
    tick();
    i_load_start = 1'b0;
    check_val("illegal_err", o_err, 1);
    check_val("illegal_ready", o_ready, 0);
    check_val("illegal_we", o_imem_we, 0);
    tick();
    check_val("illegal_stays_idle", o_ready, 0);
    check_val("illegal_core_rstn", o_core_rstn, 0);
    check_val("illegal_err_sticky", o_err, 1);

    do_load(1, 0, 1'b0);
    do_load(3, 0, 1'b1);
    do_load(4, 2, 1'b0);
    do_load(0, 0, 1'b0);
    for (int n = 0; n < 6; n++) do_load(int'($urandom_range(1, 12)), 1, 1'b0);
    do_load(1 << AW, 0, 1'b0);

    // Reset in the middle of a 5-word load, with a write pending.
    i_load_start = 1'b1;
    i_word_count = (AW+1)'(5);
    tick();
    i_load_start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      i_valid = 1'b1;
      i_data  = $urandom;
      tick();
    end
    check_val("midload_we", o_imem_we, 1);
    #2;
    i_rstn = 1'b0;
    #1;
    check_val("async_rst_we", o_imem_we, 0);
    check_val("async_rst_addr", o_imem_addr, 0);
    check_val("async_rst_wdata", o_imem_wdata, 0);
    check_val("async_rst_ready", o_ready, 0);
    check_val("async_rst_core_rstn", o_core_rstn, 0);
    i_valid = 1'b0;
    #1;
    i_rstn = 1'b1;
    tick();
    check_val("post_rst_ready", o_ready, 0);
    check_val("post_rst_core_rstn", o_core_rstn, 0);
    check_val("post_rst_we", o_imem_we, 0);

    do_load(2, 1, 1'b0);
    do_load(2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
